// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
// Holds default geometry constants, the register count those defaults imply, and helper
// functions that locate read port k inside the flattened address and data buses.
// No ports: this is a package imported by reg_file_mp and rf_read_port.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  // Low bit of port k's address field in the packed rd_addr bus.
  function automatic int rd_addr_of(input int k, input int addrW);
    return k * addrW;
  endfunction

  // Low bit of port k's data field in the packed rd_dout bus.
  function automatic int rd_data_of(input int k, input int dataW);
    return k * dataW;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port of the register file.
// Selects a register from the flattened storage, forces register 0 to zero when the
// zero register is enabled, forwards same-cycle write data when bypass is enabled, and
// optionally registers the result for a one-cycle read latency.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   rd_addr_i          address for this port
//   regs_i, busy_i     current storage contents and pending-write bits
//   wr_en_i, wr_addr_i, wr_din_i   write port, used for forwarding
//   rd_dout_o, rd_busy_o           read data and pending flag
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs_i,
  input  logic [2**ADDR_W-1:0]                busy_i,
  input  logic                                wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W-1:0]                   wr_din_i,
  output logic [DATA_W-1:0]                   rd_dout_o,
  output logic                                rd_busy_o
);

  logic              bypassHit;
  logic              isZero;
  logic [DATA_W-1:0] dout_d, dout_q;
  logic              busy_d, busy_q;

  assign bypassHit = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);
  assign isZero    = (ZERO_REG != 0) && (rd_addr_i == '0);

  // The zero register wins over forwarding; a forwarded value is never pending because
  // the write that clears it is happening right now.
  always_comb begin
    dout_d = regs_i[rd_addr_i];
    busy_d = busy_i[rd_addr_i];
    if (isZero) begin
      dout_d = '0;
      busy_d = 1'b0;
    end else if (bypassHit) begin
      dout_d = wr_din_i;
      busy_d = 1'b0;
    end
  end

  // Output stage for the registered-read variant; left unloaded when reads are combinational.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
      busy_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      busy_q <= busy_d;
    end
  end

  assign rd_dout_o = (RD_REG != 0) ? dout_q : dout_d;
  assign rd_busy_o = (RD_REG != 0) ? busy_q : busy_d;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with write-first bypass, optional hardwired
// zero register, optional registered read and a per-register pending-write scoreboard.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   rd_addr_i       NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_dout_o       NUM_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   rd_busy_o       per-port pending-write flag
//   wr_en_i, wr_addr_i, wr_din_i   writeback port (also clears the pending bit)
//   sb_set_i, sb_addr_i            issue marks a destination register pending
//   sb_flush_i                     clears every pending bit
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_dout_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_din_i,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  input  logic                     sb_flush_i
);

  localparam int NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0][DATA_W-1:0] regs_q;
  logic [NumRegs-1:0]             busy_q, busy_d;
  logic                           wrValid;

  // Writes to the hardwired zero register are dropped.
  assign wrValid = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));

  // Scoreboard next state: flush beats everything, then writeback clears, then issue sets,
  // so an issue and a writeback to the same register in one cycle leaves it pending.
  always_comb begin
    busy_d = busy_q;
    if (sb_flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
      if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Storage and scoreboard; reset wins over any write in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (wrValid) regs_q[wr_addr_i] <= wr_din_i;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .RD_REG  (RD_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rd_addr_i(rd_addr_i[rd_addr_of(k, ADDR_W) +: ADDR_W]),
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wr_en_i  (wr_en_i),
      .wr_addr_i(wr_addr_i),
      .wr_din_i (wr_din_i),
      .rd_dout_o(rd_dout_o[rd_data_of(k, DATA_W) +: DATA_W]),
      .rd_busy_o(rd_busy_o[k])
    );
  end

endmodule
